// File: rtl/vec_adder_seq.sv
// Multi-lane signed add/sub/accumulate unit sharing one adder across lanes,
// one lane per cycle, with results held behind a start/stb/ack handshake.
module vec_adder_seq #(
  parameter int WIDTH    = 64,
  parameter int LANES    = 4,
  parameter int SATURATE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   ack,
  output logic                   busy,
  output logic                   stb,
  output logic [LANES*WIDTH-1:0] z,
  output logic [LANES-1:0]       ovf
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, WAIT_ACK} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    lane_reg;
  logic [1:0]       mode_reg;
  logic [WIDTH-1:0] a_reg   [LANES];
  logic [WIDTH-1:0] b_reg   [LANES];
  logic [WIDTH-1:0] acc_reg [LANES];
  logic [WIDTH-1:0] z_reg   [LANES];
  logic [LANES-1:0] ovf_reg;

  logic [WIDTH-1:0] op_a, op_b, op_acc, sat_val, lane_res;
  logic [WIDTH:0]   sum;
  logic             lane_ovf;
  logic             last_lane;

  assign last_lane = (lane_reg == CW'(LANES - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start)     state_next = COMPUTE;
      COMPUTE:  if (last_lane) state_next = WAIT_ACK;
      WAIT_ACK: if (ack)       state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    busy = (state_reg != IDLE);
    stb  = (state_reg == WAIT_ACK);
  end

  // Shared lane datapath: one (WIDTH+1)-bit sign-extended add per cycle
  always_comb begin
    op_a   = a_reg[lane_reg];
    op_b   = b_reg[lane_reg];
    op_acc = acc_reg[lane_reg];
    sum    = '0;
    case (mode_reg)
      2'b00:   sum = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
      2'b01:   sum = {op_a[WIDTH-1], op_a} - {op_b[WIDTH-1], op_b};
      2'b10:   sum = {op_acc[WIDTH-1], op_acc} + {op_a[WIDTH-1], op_a};
      default: sum = '0;
    endcase
    lane_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    // The extra top bit is the true sign, so it picks the clamp direction
    sat_val  = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    lane_res = ((SATURATE != 0) && lane_ovf) ? sat_val : sum[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_reg <= '0;
      mode_reg <= '0;
      ovf_reg  <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        acc_reg[i] <= '0;
        z_reg[i]   <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg <= mode;
            lane_reg <= '0;
            ovf_reg  <= '0;
            for (int i = 0; i < LANES; i++) begin
              a_reg[i] <= a[i*WIDTH +: WIDTH];
              b_reg[i] <= b[i*WIDTH +: WIDTH];
            end
          end
        end
        COMPUTE: begin
          z_reg[lane_reg] <= lane_res;
          if (lane_ovf) ovf_reg[lane_reg] <= 1'b1;
          if (mode_reg == 2'b10) acc_reg[lane_reg] <= lane_res;
          if (mode_reg == 2'b11) acc_reg[lane_reg] <= '0;
          lane_reg <= last_lane ? '0 : lane_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_pack
      assign z[gi*WIDTH +: WIDTH] = z_reg[gi];
    end
  endgenerate

  assign ovf = ovf_reg;

endmodule
